riscv_pipe_skid_reg: RTL and testbench

Parametrised pipeline-stage register for the RISC-V core. It replaces the fixed-field, always-advancing stage registers such as MEM/WB with a generic payload bus and a valid/ready handshake. It also supports stall, flush and an optional skid buffer. It sits between any two core stages, for example EX/MEM or MEM/WB, carrying the packed control/data bundle.

---
 rtl/riscv_pipe_skid_reg.sv | 70 +++++++
 tb/tb_riscv_pipe_skid_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_skid_reg.sv
// riscv_pipe_skid_reg: valid/ready pipeline-stage register with flush and an optional
// two-entry skid buffer; occupancy doubles as the FSM state.
module riscv_pipe_skid_reg #(
    parameter int DATA_W = 40,
    parameter int SKID = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] main_q, skid_q;
    logic in_xfer, out_xfer, ld_main, ld_skid, from_skid;

    // Skid mode decodes in_ready from state only, so out_ready never reaches upstream.
    assign in_ready  = (SKID != 0) ? (state != TWO) : (state == EMPTY || out_ready);
    assign out_valid = state != EMPTY;
    assign occupancy = state;
    assign out_data  = main_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_nx  = state;
        ld_main   = 1'b0;
        ld_skid   = 1'b0;
        from_skid = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    state_nx = in_xfer ? ONE : EMPTY;
                    ld_main  = in_xfer;
                end
                ONE: begin
                    state_nx = (in_xfer && !out_xfer) ? TWO : (out_xfer && !in_xfer) ? EMPTY : ONE;
                    ld_main  = in_xfer && out_xfer;
                    ld_skid  = in_xfer && !out_xfer;
                end
                TWO: begin
                    state_nx  = out_xfer ? ONE : TWO;
                    ld_main   = out_xfer;
                    from_skid = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nx;
            if (ld_main) main_q <= from_skid ? skid_q : in_data;
            if (ld_skid) skid_q <= in_data;
        end
    end
endmodule

// File: tb/tb_riscv_pipe_skid_reg.sv
// tb_riscv_pipe_skid_reg: drives a SKID=1 and a SKID=0 instance with shared random and
// directed stimulus, checking both against queue-based reference models every cycle.
module tb_riscv_pipe_skid_reg;
    localparam int DW = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [1:0] occ1, occ0;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last0 = '0;
    bit mo1, mi1, mo0, mi0;

    always #5 clk = ~clk;

    riscv_pipe_skid_reg #(.DATA_W(DW), .SKID(1)) d1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    riscv_pipe_skid_reg #(.DATA_W(DW), .SKID(0)) d0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a FIFO of held payloads; out_data shows the head, or the last head once drained.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q1.delete();
            q0.delete();
            last1 = '0;
            last0 = '0;
        end else begin
            mo1 = q1.size() > 0 && out_ready;
            mi1 = in_valid && q1.size() < 2;
            mo0 = q0.size() > 0 && out_ready;
            mi0 = in_valid && (q0.size() == 0 || out_ready);
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (mo1) void'(q1.pop_front());
                if (mi1) q1.push_back(in_data);
                if (mo0) void'(q0.pop_front());
                if (mi0) q0.push_back(in_data);
            end
            if (q1.size() > 0) last1 = q1[0];
            if (q0.size() > 0) last0 = q0[0];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m1_valid", 64'(out_valid1), 64'(q1.size() > 0));
            chk("m1_ready", 64'(in_ready1), 64'(q1.size() < 2));
            chk("m1_occ", 64'(occ1), 64'(q1.size()));
            chk("m1_data", 64'(out_data1), 64'(last1));
            chk("m0_valid", 64'(out_valid0), 64'(q0.size() > 0));
            chk("m0_ready", 64'(in_ready0), 64'(q0.size() == 0 || out_ready));
            chk("m0_occ", 64'(occ0), 64'(q0.size()));
            chk("m0_data", 64'(out_data0), 64'(last0));
        end
    end

    initial begin
        #1;
        chk("rst_valid", 64'(out_valid1), 64'd0);
        chk("rst_occ", 64'(occ1), 64'd0);
        chk("rst_data", 64'(out_data1), 64'd0);
        chk("rst_ready", 64'(in_ready1), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Streaming at full throughput.
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = DW'(i);
            step();
            chk("stream_data", 64'(out_data1), 64'(i));
            chk("stream_occ", 64'(occ1), 64'd1);
            chk("stream_ready", 64'(in_ready1), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("drain_occ", 64'(occ1), 64'd0);

        // Backpressure fills the skid entry, then drains in order.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = DW'('hA1);
        step();
        in_data = DW'('hA2);
        step();
        in_data = DW'('hA3);
        step();
        chk("bp_occ", 64'(occ1), 64'd2);
        chk("bp_ready", 64'(in_ready1), 64'd0);
        chk("bp_head", 64'(out_data1), 64'hA1);
        out_ready = 1'b1;
        step();
        chk("bp_out2", 64'(out_data1), 64'hA2);
        step();
        chk("bp_out3", 64'(out_data1), 64'hA3);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 64'(occ1), 64'd0);

        // Flush with a payload on offer.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = DW'('hB1);
        step();
        in_data = DW'('hB2);
        step();
        chk("fl_full", 64'(occ1), 64'd2);
        flush = 1'b1;
        in_data = DW'('hB3);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid1), 64'd0);
        chk("fl_occ", 64'(occ1), 64'd0);
        chk("fl_ready", 64'(in_ready1), 64'd1);
        chk("fl_data", 64'(out_data1), 64'hB1);
        out_ready = 1'b1;
        step();
        chk("fl_after", 64'(out_valid1), 64'd0);

        // Single-entry mode: combinational in_ready from out_ready.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = DW'('hC1);
        step();
        in_valid = 1'b0;
        chk("s0_occ", 64'(occ0), 64'd1);
        chk("s0_stall", 64'(in_ready0), 64'd0);
        chk("s0_head", 64'(out_data0), 64'hC1);
        in_valid = 1'b1;
        in_data = DW'('hC2);
        out_ready = 1'b1;
        #1;
        chk("s0_ready", 64'(in_ready0), 64'd1);
        step();
        chk("s0_data", 64'(out_data0), 64'hC2);
        chk("s0_occ1", 64'(occ0), 64'd1);
        in_valid = 1'b0;
        step();
        step();

        // Asynchronous reset while full.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = DW'('hD1);
        step();
        in_data = DW'('hD2);
        step();
        chk("ar_full", 64'(occ1), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid1), 64'd0);
        chk("ar_occ", 64'(occ1), 64'd0);
        chk("ar_data", 64'(out_data1), 64'd0);
        chk("ar_ready", 64'(in_ready1), 64'd1);
        in_valid = 1'b0;
        step();
        rst = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 64) == 0;
            in_data = DW'({$urandom, $urandom});
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
